// File: rtl/pool_pkg.sv
// Shared constants, FSM state type and elaboration-time helpers for the pooling stage.
package pool_pkg;

  localparam int unsigned MODE_MAX = 0;
  localparam int unsigned MODE_AVG = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 32'd1 : clog2(n);
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int unsigned k, input int unsigned h,
                                   input int unsigned w);
    return is_pow2(k) && (h >= k) && (w >= k);
  endfunction

endpackage

// File: rtl/pool_window_alu.sv
// Combinational window reducer: folds one element into the running accumulator
// and produces the finalised (shifted, optionally rectified, truncated) result.
module pool_window_alu
  import pool_pkg::*;
#(
  parameter int unsigned DW     = 19,
  parameter int unsigned K      = 2,
  parameter int unsigned MODE   = MODE_MAX,
  parameter int unsigned SIGNED = 1,
  parameter int unsigned RELU   = 0,
  localparam int unsigned SH    = 2 * clog2(K),
  localparam int unsigned AW    = DW + SH
) (
  input  logic [AW-1:0] acc,
  input  logic [DW-1:0] elem,
  input  logic          first,
  output logic [AW-1:0] acc_next_c,
  output logic [DW-1:0] result_c
);

  logic [AW-1:0] elem_x;
  logic [AW-1:0] fin;

  always_comb begin
    elem_x     = '0;
    acc_next_c = '0;
    fin        = '0;
    result_c   = '0;

    if (SIGNED != 0) elem_x = AW'($signed(elem));
    else             elem_x = AW'(elem);

    if (first) begin
      acc_next_c = elem_x;
    end else if (MODE == MODE_AVG) begin
      acc_next_c = acc + elem_x;
    end else if (SIGNED != 0) begin
      acc_next_c = ($signed(elem_x) > $signed(acc)) ? elem_x : acc;
    end else begin
      acc_next_c = (elem_x > acc) ? elem_x : acc;
    end

    // Average divides by K*K with a flooring shift; max passes straight through.
    fin = acc_next_c;
    if (MODE == MODE_AVG) begin
      if (SIGNED != 0) fin = AW'($signed(acc_next_c) >>> SH);
      else             fin = acc_next_c >> SH;
    end

    if ((RELU != 0) && (SIGNED != 0) && fin[AW-1]) fin = '0;

    result_c = DW'(fin);
  end

endmodule

// File: rtl/pool2d_seq.sv
// Sequential K x K pooling stage: captures a flat multi-channel map on a valid
// pulse, scans it one element per clock and publishes the pooled map with ready.
module pool2d_seq
  import pool_pkg::*;
#(
  parameter int unsigned DW     = 19,
  parameter int unsigned H      = 10,
  parameter int unsigned W      = 10,
  parameter int unsigned CH     = 1,
  parameter int unsigned K      = 2,
  parameter int unsigned MODE   = MODE_MAX,
  parameter int unsigned SIGNED = 1,
  parameter int unsigned RELU   = 0,
  localparam int unsigned OH    = H / K,
  localparam int unsigned OW    = W / K
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [CH*H*W*DW-1:0]    layer_in,
  output logic [CH*OH*OW*DW-1:0]  layer_out,
  output logic                    ready,
  output logic                    busy
);

  localparam int unsigned NIN  = CH * H * W;
  localparam int unsigned NOUT = CH * OH * OW;
  localparam int unsigned SH   = 2 * clog2(K);
  localparam int unsigned AW   = DW + SH;
  localparam int unsigned KW   = cnt_w(K);
  localparam int unsigned OYW  = cnt_w(OH);
  localparam int unsigned OXW  = cnt_w(OW);
  localparam int unsigned CW   = cnt_w(CH);
  localparam int unsigned IAW  = cnt_w(NIN);
  localparam int unsigned OAW  = cnt_w(NOUT);

  if (!params_ok(K, H, W)) begin : g_bad_params
    $error("pool2d_seq: K must be a power of two no larger than H or W");
  end

  state_e state, state_next;

  logic [KW-1:0]  kx, ky;
  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;
  logic [CW-1:0]  c;
  logic [AW-1:0]  acc, acc_next_c;
  logic [DW-1:0]  result_c;

  logic [NIN-1:0][DW-1:0]  in_buf;
  logic [NOUT-1:0][DW-1:0] work_buf;
  logic [IAW-1:0]          rd_idx;
  logic [OAW-1:0]          wr_idx;

  logic kx_last, ky_last, ox_last, oy_last, c_last;
  logic win_first, win_last, frame_last;
  logic load_in, scan_en, load_out;

  assign kx_last    = (kx == KW'(K - 1));
  assign ky_last    = (ky == KW'(K - 1));
  assign ox_last    = (ox == OXW'(OW - 1));
  assign oy_last    = (oy == OYW'(OH - 1));
  assign c_last     = (c == CW'(CH - 1));
  assign win_first  = (kx == '0) && (ky == '0);
  assign win_last   = kx_last && ky_last;
  assign frame_last = win_last && ox_last && oy_last && c_last;

  // Only the K-aligned region is ever addressed, so partial edge windows drop out.
  assign rd_idx = IAW'(((32'(c) * H + 32'(oy) * K + 32'(ky)) * W) + 32'(ox) * K + 32'(kx));
  assign wr_idx = OAW'((32'(c) * OH + 32'(oy)) * OW + 32'(ox));

  pool_window_alu #(
    .DW    (DW),
    .K     (K),
    .MODE  (MODE),
    .SIGNED(SIGNED),
    .RELU  (RELU)
  ) u_alu (
    .acc       (acc),
    .elem      (in_buf[rd_idx]),
    .first     (win_first),
    .acc_next_c(acc_next_c),
    .result_c  (result_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    load_in    = 1'b0;
    scan_en    = 1'b0;
    load_out   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid) begin
          load_in    = 1'b1;
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_en = 1'b1;
        if (frame_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        load_out   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Scan counters, innermost kx through outermost c.
  always_ff @(posedge clk) begin
    if (!rst || load_in) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
      c  <= '0;
    end else if (scan_en) begin
      if (!kx_last) begin
        kx <= kx + KW'(1);
      end else begin
        kx <= '0;
        if (!ky_last) begin
          ky <= ky + KW'(1);
        end else begin
          ky <= '0;
          if (!ox_last) begin
            ox <= ox + OXW'(1);
          end else begin
            ox <= '0;
            if (!oy_last) begin
              oy <= oy + OYW'(1);
            end else begin
              oy <= '0;
              c  <= c_last ? '0 : c + CW'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)         acc <= '0;
    else if (scan_en) acc <= acc_next_c;
  end

  // Frame buffers carry data only; their contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (load_in) in_buf <= layer_in;
    if (scan_en && win_last) work_buf[wr_idx] <= result_c;
  end

  // Registered outputs; layer_out moves only on the DONE edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      layer_out <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (load_out) layer_out <= work_buf;
      ready <= load_out;
      busy  <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pool2d_seq.sv
// Self-checking bench for pool2d_seq: a default-parameter instance driven from a
// vector table through a scoreboard, plus small instances for signed/ReLU, average and edge windows.
module tb_pool2d_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic vld [5];
  logic rdy [5];
  logic bsy [5];

  logic [1899:0] din0;
  logic [474:0]  out0;
  logic [383:0]  din1;
  logic [95:0]   out1, out2;
  logic [63:0]   din3;
  logic [15:0]   out3;
  logic [399:0]  din4;
  logic [63:0]   out4;

  pool2d_seq u0 (.clk(clk), .rst(rst), .valid(vld[0]), .layer_in(din0), .layer_out(out0),
                 .ready(rdy[0]), .busy(bsy[0]));

  pool2d_seq #(.DW(8), .H(4), .W(4), .CH(3), .K(2), .MODE(0), .SIGNED(1), .RELU(0)) u1 (
    .clk(clk), .rst(rst), .valid(vld[1]), .layer_in(din1), .layer_out(out1),
    .ready(rdy[1]), .busy(bsy[1]));

  pool2d_seq #(.DW(8), .H(4), .W(4), .CH(3), .K(2), .MODE(0), .SIGNED(1), .RELU(1)) u2 (
    .clk(clk), .rst(rst), .valid(vld[2]), .layer_in(din1), .layer_out(out2),
    .ready(rdy[2]), .busy(bsy[2]));

  pool2d_seq #(.DW(8), .H(2), .W(4), .CH(1), .K(2), .MODE(1), .SIGNED(1), .RELU(0)) u3 (
    .clk(clk), .rst(rst), .valid(vld[3]), .layer_in(din3), .layer_out(out3),
    .ready(rdy[3]), .busy(bsy[3]));

  pool2d_seq #(.DW(16), .H(5), .W(5), .CH(1), .K(2), .MODE(0), .SIGNED(1), .RELU(0)) u4 (
    .clk(clk), .rst(rst), .valid(vld[4]), .layer_in(din4), .layer_out(out4),
    .ready(rdy[4]), .busy(bsy[4]));

  task automatic chk(input string nm, input logic [474:0] act, input logic [474:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Scoreboard for u0: expected frame plus the cycle stamp taken just after its valid edge.
  typedef struct {
    logic [474:0] exp;
    int           t;
  } sb_t;
  sb_t sb_q[$];
  logic prev_rdy0 = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      prev_rdy0 = 1'b0;
    end else begin
      if (rdy[0]) begin : pop_blk
        sb_t e;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL u0_unexpected_ready: got ready at cycle %0d required none", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("u0_frame", out0, e.exp);
          chk_int("u0_latency", cyc - e.t, 101);
          chk_int("u0_busy_at_ready", int'(bsy[0]), 0);
        end
        chk_int("u0_ready_width", int'(prev_rdy0), 0);
      end
      prev_rdy0 = rdy[0];
    end
  end

  task automatic send0(input logic [1899:0] d, input logic [474:0] e);
    din0   = d;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    sb_q.push_back('{exp: e, t: cyc});
  endtask

  // Waits (bounded) for ready on one instance; lat counts clocks from the valid edge.
  task automatic wait_rdy(input int which, input int budget, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (rdy[which]) begin
        lat = i;
        break;
      end
      if (!bsy[which]) busy_ok = 1'b0;
    end
  endtask

  function automatic logic [18:0] max_ref(input logic [1899:0] d, input int oy, input int ox);
    logic signed [18:0] m, v;
    m = d[(2 * oy * 10 + 2 * ox) * 19 +: 19];
    for (int ky = 0; ky < 2; ky++)
      for (int kx = 0; kx < 2; kx++) begin
        v = d[((2 * oy + ky) * 10 + 2 * ox + kx) * 19 +: 19];
        if (v > m) m = v;
      end
    return m;
  endfunction

  typedef struct {
    string         name;
    logic [1899:0] din;
    logic [474:0]  exp;
  } vec_t;
  vec_t vecs[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit bok;
    logic [7:0] v8;

    for (int i = 0; i < 5; i++) vld[i] = 1'b0;
    din0 = '0; din1 = '0; din3 = '0; din4 = '0;

    vecs[0].name = "ramp";
    vecs[1].name = "reverse";
    vecs[2].name = "random";
    for (int e = 0; e < 100; e++) begin
      vecs[0].din[e*19 +: 19] = 19'(e);
      vecs[1].din[e*19 +: 19] = 19'(99 - e);
      vecs[2].din[e*19 +: 19] = 19'($urandom);
    end
    for (int oy = 0; oy < 5; oy++)
      for (int ox = 0; ox < 5; ox++) begin
        vecs[0].exp[(oy*5+ox)*19 +: 19] = 19'((2*oy+1)*10 + 2*ox + 1);
        vecs[1].exp[(oy*5+ox)*19 +: 19] = 19'(99 - (20*oy + 2*ox));
        vecs[2].exp[(oy*5+ox)*19 +: 19] = max_ref(vecs[2].din, oy, ox);
      end

    repeat (3) @(negedge clk);
    chk("reset_out0", out0, '0);
    chk_int("reset_ready0", int'(rdy[0]), 0);
    chk_int("reset_busy0", int'(bsy[0]), 0);
    chk("reset_out4", 475'(out4), '0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven frames through the scoreboard.
    for (int v = 0; v < 3; v++) begin
      send0(vecs[v].din, vecs[v].exp);
      wait_rdy(0, 140, lat, bok);
      chk_int({"u0_done_", vecs[v].name}, int'(lat > 0), 1);
      chk_int({"u0_busy_scan_", vecs[v].name}, int'(bok), 1);
    end
    chk("u0_out24_ramp_then_random", out0, vecs[2].exp);

    // valid mid-scan is ignored; old frame held until DONE.
    send0(vecs[0].din, vecs[0].exp);
    wait_rdy(0, 140, lat, bok);
    send0(vecs[1].din, vecs[1].exp);
    repeat (30) @(negedge clk);
    din0 = vecs[2].din;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (18) @(negedge clk);
    chk("u0_hold_old_frame", out0, vecs[0].exp);
    wait_rdy(0, 140, lat, bok);
    chk_int("u0_midscan_done", int'(lat > 0), 1);
    repeat (110) @(negedge clk);

    // Back-to-back: valid during the ready cycle.
    send0(vecs[2].din, vecs[2].exp);
    wait_rdy(0, 140, lat, bok);
    send0(vecs[0].din, vecs[0].exp);
    wait_rdy(0, 140, lat, bok);
    chk_int("u0_b2b_done", int'(lat > 0), 1);

    // Reset mid-scan: aborted frame must vanish.
    send0(vecs[1].din, vecs[1].exp);
    repeat (39) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("u0_rst_out", out0, '0);
    chk_int("u0_rst_ready", int'(rdy[0]), 0);
    chk_int("u0_rst_busy", int'(bsy[0]), 0);
    rst = 1'b1;
    repeat (110) @(negedge clk);
    send0(vecs[0].din, vecs[0].exp);
    wait_rdy(0, 140, lat, bok);
    chk_int("u0_after_rst_done", int'(lat > 0), 1);

    // Signed max with and without ReLU, three channels.
    for (int e = 0; e < 48; e++) din1[e*8 +: 8] = 8'hFB;
    din1[(32 + 0) * 8 +: 8] = 8'hFF;
    din1[(32 + 1) * 8 +: 8] = 8'hF9;
    din1[(32 + 4) * 8 +: 8] = 8'hFD;
    din1[(32 + 5) * 8 +: 8] = 8'hF7;
    vld[1] = 1'b1; vld[2] = 1'b1;
    @(negedge clk);
    vld[1] = 1'b0; vld[2] = 1'b0;
    wait_rdy(1, 80, lat, bok);
    chk_int("u1_latency", lat, 49);
    chk_int("u1_busy_scan", int'(bok), 1);
    chk("u1_relu0", 475'(out1), 475'({{3{8'hFB}}, 8'hFF, {8{8'hFB}}}));
    chk("u2_relu1", 475'(out2), '0);

    // Average with flooring shift.
    din3 = {8'hFC, 8'hFD, 8'd16, 8'd12, 8'hFE, 8'hFF, 8'd8, 8'd4};
    vld[3] = 1'b1;
    @(negedge clk);
    vld[3] = 1'b0;
    wait_rdy(3, 30, lat, bok);
    chk_int("u3_latency", lat, 9);
    chk("u3_avg_a", 475'(out3), 475'({8'hFD, 8'd10}));
    din3 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF, 8'd0, 8'd7};
    vld[3] = 1'b1;
    @(negedge clk);
    vld[3] = 1'b0;
    wait_rdy(3, 30, lat, bok);
    v8 = 8'hFF;
    chk("u3_avg_b", 475'(out3), 475'({v8, 8'd1}));

    // Partial windows: row 4 and column 4 never read.
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        din4[(y*5+x)*16 +: 16] = (y == 4 || x == 4) ? 16'd1000 : 16'(y*5 + x + 1);
    vld[4] = 1'b1;
    @(negedge clk);
    vld[4] = 1'b0;
    wait_rdy(4, 40, lat, bok);
    chk("u4_edge_ramp", 475'(out4), 475'({16'd19, 16'd17, 16'd9, 16'd7}));
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        din4[(y*5+x)*16 +: 16] = (y == 4 || x == 4) ? 16'd1000 : 16'd0;
    vld[4] = 1'b1;
    @(negedge clk);
    vld[4] = 1'b0;
    wait_rdy(4, 40, lat, bok);
    chk_int("u4_latency", lat, 17);
    chk("u4_edge_zero", 475'(out4), '0);

    repeat (5) @(negedge clk);
    chk_int("u0_sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
